vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Frame-buffer access scheduler between the VGA timing generator and a single-port pixel memory (1 port, 1-cycle read latency). Each clock it grants the memory port to either the display read stream (addressed from hPix/vPix) or a host write requester (valid/ready), and returns display pixels in pixel order. Display reads have absolute priority. An optional tear-free mode restricts host writes to vertical blanking.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- DATA_W, 8, pixel width (RGB332)
- ADDR_W, 19, memory address width (must hold H_ACTIVE*V_ACTIVE-1)

Ports:
- clk  in  1  system clock (50 MHz)
- n_rst  in  1  reset; one clock; reset is asynchronous and active-low
- pix_en  in  1  one-cycle strobe per pixel from timing generator (every 2nd clk)
- hPix, vPix  in  10 each  current pixel; all ones = blanking
- wr_vblank_only  in  1  1 = host writes accepted only in VBLANK state
- wr_valid  in  1  host write request
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready
- wr_addr  in  ADDR_W  linear pixel address (y*H_ACTIVE+x)
- wr_data  in  DATA_W  pixel value
- mem_addr  out  ADDR_W; mem_re, mem_we  out  1 each; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W
- pix_data  out  DATA_W  pixel to DAC; 0 when not valid
- pix_valid  out  1  pix_data is a visible pixel
- frame_start  out  1  one-cycle pulse at start of each visible frame
- frame_cnt  out  16  frames started, wraps 0xFFFF -> 0

## Operation
- active = pix_en & (hPix < H_ACTIVE) & (vPix < V_ACTIVE).
- Read slot: when active, mem_re=1, mem_we=0, mem_addr = vPix*H_ACTIVE + hPix (shift-add, no multiplier).
- Write slot: wr_ready = !active & gate; gate = !wr_vblank_only | (state==VBLANK). On wr_valid & wr_ready: if wr_addr < H_ACTIVE*V_ACTIVE, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; else write dropped (still handshaken, mem_we=0).
- mem_re/mem_we never both 1; neither asserted in an idle cycle (mem_addr don't-care then).
- State machine (evaluated on pix_en only):
  - DISP -> VBLANK when vPix >= V_ACTIVE (including all-ones).
  - VBLANK -> DISP when vPix == 0 and hPix == 0; same cycle registers frame_start=1 and increments frame_cnt.
- wr_vblank_only may change any cycle; takes effect on the same cycle's wr_ready.
- wr_ready is combinational from pix_en/hPix/vPix/state/wr_vblank_only; it must not depend on wr_valid.

## Timing
- Reset values: state=DISP, pix_data=0, pix_valid=0, frame_start=0, frame_cnt=0, internal valid pipeline cleared; mem_re/mem_we=0 while n_rst low.
- Read latency: read issued cycle t; mem_rdata valid cycle t+1; pix_data/pix_valid registered, visible cycle t+2.
- pix_valid = active delayed 2 cycles; pix_data holds the last value between pixels; on a non-visible pix_en, pix_data=0 and pix_valid=0 at t+2.
- Write takes effect in the handshake cycle; zero latency to mem_we.
- With pix_en every 2nd cycle, a write is accepted within 2 cycles in non-restricted mode.
- Reset mid-frame: pipeline flushed, restart in DISP; no frame_start until next vBLANK->visible transition.

## Structure
- Package vga_pkg: H_ACTIVE/V_ACTIVE defaults, pixel_t (logic [DATA_W-1:0]), fb_state_t enum {DISP, VBLANK}.
- Sub-module vga_addr_gen: combinational hPix/vPix -> linear address ((vPix<<9)+(vPix<<7)+hPix for 640).

## Test plan
- pix_en at (h=5,v=2), mem_rdata=0xA5 next cycle -> mem_re=1, mem_addr=1285; pix_data=0xA5, pix_valid=1 two cycles after pix_en.
- wr_valid with pix_en high at visible pixel -> wr_ready=0, mem_we=0; next (non-pix_en) cycle wr_ready=1, mem_we=1, mem_addr=wr_addr.
- wr_vblank_only=1, v=100 -> wr_ready=0 always; after pix_en at v=480 -> wr_ready=1 on non-read cycles.
- pix_en at (0,0) after blanking -> frame_start one cycle, frame_cnt 0->1; from 0xFFFF wraps to 0.
- wr_addr=307200 -> handshake completes, mem_we=0.
- n_rst low at v=200 mid-read -> pix_valid, pix_data, frame_cnt 0 immediately; state DISP.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared defaults and types for the VGA frame-buffer arbiter and its address generator.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int DATA_W_DEF   = 8;
  localparam int COORD_W      = 10;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  typedef enum logic [0:0] {
    DISP   = 1'b0,
    VBLANK = 1'b1
  } fb_state_t;

  // Number of pixels in one visible frame.
  function automatic int fb_size(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/vga_addr_gen.sv
// Converts a (hPix, vPix) pixel coordinate into a linear frame-buffer address
// using only shifts and adders (vPix * H_ACTIVE is a constant multiply).
module vga_addr_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic [COORD_W-1:0] h_pix_i,
  input  logic [COORD_W-1:0] v_pix_i,
  output logic [ADDR_W-1:0]  addr_o
);

  localparam logic [ADDR_W-1:0] H_K = ADDR_W'(H_ACTIVE);

  logic [ADDR_W-1:0] v_ext_s;
  logic [ADDR_W-1:0] sum_s;

  assign v_ext_s = ADDR_W'(v_pix_i);

  // Add one shifted copy of vPix per set bit of the line length, on top of hPix
  // (for 640 this reduces to (vPix<<9) + (vPix<<7) + hPix).
  always_comb begin
    sum_s = ADDR_W'(h_pix_i);
    for (int b = 0; b < ADDR_W; b++) begin
      if (H_K[b]) begin
        sum_s = sum_s + (v_ext_s << b);
      end else begin
        sum_s = sum_s;
      end
    end
  end

  assign addr_o = sum_s;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port scheduler: display reads always win the single memory
// port; host writes use the remaining cycles, optionally only during VBLANK.
// Display pixels come back two cycles after the read is issued.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                pix_en,
  input  logic [COORD_W-1:0]  hPix,
  input  logic [COORD_W-1:0]  vPix,
  input  logic                wr_vblank_only,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   pix_data,
  output logic                pix_valid,
  output logic                frame_start,
  output logic [15:0]         frame_cnt
);

  localparam logic [ADDR_W:0]    FB_WORDS = (ADDR_W+1)'(fb_size(H_ACTIVE, V_ACTIVE));
  localparam logic [COORD_W-1:0] H_LIM    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM    = COORD_W'(V_ACTIVE);

  fb_state_t          state_q, state_d;
  logic               frame_start_q, frame_start_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               rd_pend_q;
  logic               blank_pend_q;
  logic               pix_valid_q;
  logic [DATA_W-1:0]  pix_data_q;

  logic               h_vis_s;
  logic               v_vis_s;
  logic               active_s;
  logic               gate_s;
  logic               wr_ready_s;
  logic               wr_fire_s;
  logic               wr_in_range_s;
  logic [ADDR_W-1:0]  rd_addr_s;

  vga_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .h_pix_i (hPix),
    .v_pix_i (vPix),
    .addr_o  (rd_addr_s)
  );

  // A read slot is any pixel strobe on a visible coordinate; nothing is
  // granted while reset is held so the memory sees no strobes.
  assign h_vis_s       = (hPix < H_LIM);
  assign v_vis_s       = (vPix < V_LIM);
  assign active_s      = n_rst & pix_en & h_vis_s & v_vis_s;
  assign gate_s        = ~wr_vblank_only | (state_q == VBLANK);
  assign wr_ready_s    = n_rst & ~active_s & gate_s;
  assign wr_fire_s     = wr_valid & wr_ready_s;
  assign wr_in_range_s = ({1'b0, wr_addr} < FB_WORDS);
  assign wr_ready      = wr_ready_s;

  // Memory port mux: display read first, then an accepted in-range write, else idle.
  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (active_s) begin
      mem_re   = 1'b1;
      mem_addr = rd_addr_s;
    end else if (wr_fire_s && wr_in_range_s) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else begin
      mem_re = 1'b0;
    end
  end

  // Frame state next-state logic; only advances on pixel strobes.
  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (pix_en) begin
      case (state_q)
        DISP: begin
          if (!v_vis_s) begin
            state_d = VBLANK;
          end else begin
            state_d = DISP;
          end
        end
        VBLANK: begin
          if ((vPix == {COORD_W{1'b0}}) && (hPix == {COORD_W{1'b0}})) begin
            state_d       = DISP;
            frame_start_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
          end else begin
            state_d = VBLANK;
          end
        end
        default: begin
          state_d = DISP;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame state, frame-start pulse and frame counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= DISP;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  // Two-stage pixel return: stage 1 remembers what was issued, stage 2
  // captures the memory data (or blanks it) into the output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_pend_q    <= 1'b0;
      blank_pend_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= {DATA_W{1'b0}};
    end else begin
      rd_pend_q    <= active_s;
      blank_pend_q <= pix_en & ~active_s;
      pix_valid_q  <= rd_pend_q;
      if (rd_pend_q) begin
        pix_data_q <= mem_rdata;
      end else if (blank_pend_q) begin
        pix_data_q <= {DATA_W{1'b0}};
      end else begin
        pix_data_q <= pix_data_q;
      end
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
